// File: rtl/pc_unit.sv
// Program counter for the picoMIPS datapath plus the ready push-switch synchroniser.
// Define READY_DEBOUNCE_EN to add a DB_CYCLES-edge debounce filter behind the synchroniser.
module pc_unit #(
  parameter int unsigned PSIZE     = 6,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             pc_incr,
  input  logic             pc_abs,
  input  logic             pc_rel,
  input  logic [PSIZE-1:0] branch_addr,
  input  logic             ready_sw,
  output logic             ready,
  output logic [PSIZE-1:0] pc
);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("DB_CYCLES must be at least 2");
  end

  logic [PSIZE-1:0] pc_q, pc_d;
  logic             sync1_q, sync2_q;

  // Same-width two's-complement add wraps exactly like pc + sext(offset) mod 2^PSIZE.
  always_comb begin
    pc_d = pc_q;
    if (pc_abs) begin
      pc_d = branch_addr;
    end else if (pc_rel) begin
      pc_d = pc_q + branch_addr;
    end else if (pc_incr) begin
      pc_d = pc_q + PSIZE'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q    <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sync1_q <= ready_sw;
      sync2_q <= sync1_q;
    end
  end

  assign pc = pc_q;

`ifdef READY_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  logic [CntW-1:0] count_q, count_d;
  logic            ready_q, ready_d;

  // Any edge where the synchronised level agrees with ready discards the pending change.
  always_comb begin
    ready_d = ready_q;
    count_d = '0;
    if (sync2_q != ready_q) begin
      if (count_q == CntW'(DB_CYCLES - 1)) begin
        ready_d = sync2_q;
      end else begin
        count_d = count_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
`else
  assign ready = sync2_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the stimulus side pushes model predictions, a monitor compares.
// The ready model follows READY_DEBOUNCE_EN, matching whichever build is compiled.
module tb_pc_unit;

  localparam int PS = 6;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          n_reset, pc_incr, pc_abs, pc_rel, ready_sw, ready;
  logic [PS-1:0] branch_addr, pc;

  always #5 clk = ~clk;

  pc_unit #(.PSIZE(PS), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .pc_incr     (pc_incr),
    .pc_abs      (pc_abs),
    .pc_rel      (pc_rel),
    .branch_addr (branch_addr),
    .ready_sw    (ready_sw),
    .ready       (ready),
    .pc          (pc)
  );

  typedef struct packed {
    logic [PS-1:0] pc;
    logic          ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state: pc as a plain integer, switch samples newest-first (hist[0] = last edge).
  int   m_pc;
  bit   m_ready;
  bit   hist[$];

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic void model_clear();
    m_pc    = 0;
    m_ready = 1'b0;
    hist.delete();
    for (int k = 0; k < DB + 2; k++) hist.push_back(1'b0);
  endfunction

  function automatic void model_edge(input bit i, input bit a, input bit r,
                                     input int addr, input bit sw);
    int  off;
    bit  flip;
    off = (addr >= 2 ** (PS - 1)) ? addr - 2 ** PS : addr;
    if (a)      m_pc = addr;
    else if (r) m_pc = (m_pc + off + 2 ** PS) % (2 ** PS);
    else if (i) m_pc = (m_pc + 1) % (2 ** PS);
`ifdef READY_DEBOUNCE_EN
    // Level seen by the filter at this edge is hist[1]; it flips after DB disagreeing edges.
    flip = 1'b1;
    for (int k = 1; k <= DB; k++) if (hist[k] == m_ready) flip = 1'b0;
    if (flip) m_ready = ~m_ready;
`else
    flip    = 1'b0;
    m_ready = hist[0] | flip;
`endif
    hist.push_front(sw);
    void'(hist.pop_back());
  endfunction

  task automatic cycle(input bit rstn, input bit i, input bit a, input bit r,
                       input logic [PS-1:0] addr, input bit sw);
    exp_t e;
    @(negedge clk);
    n_reset     = rstn;
    pc_incr     = i;
    pc_abs      = a;
    pc_rel      = r;
    branch_addr = addr;
    ready_sw    = sw;
    if (!rstn) model_clear();
    else model_edge(i, a, r, int'(addr), sw);
    e.pc    = PS'(m_pc);
    e.ready = m_ready;
    exp_q.push_back(e);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset(input bit sw);
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    check("reset_pc_async", int'(pc), 0);
    check("reset_ready_async", int'(ready), 0);
    model_clear();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, sw);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, sw);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", int'(pc), int'(e.pc));
        check("ready", int'(ready), int'(e.ready));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", exp_q.size());
    $fatal(1);
  end

  initial begin : stim
    bit sw_r;
    int run;
    n_reset = 1'b0; pc_incr = 1'b0; pc_abs = 1'b0; pc_rel = 1'b0;
    branch_addr = '0; ready_sw = 1'b0;
    model_clear();
    #3;
    check("init_pc", int'(pc), 0);
    check("init_ready", int'(ready), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Increment through the wrap, then reset mid-cycle and count again.
    for (int n = 0; n < 20; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    do_reset(1'b0);
    for (int n = 0; n < 70; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);

    // Branches and priority.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd10, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 6'b111101, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd42, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 6'b111101, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 6'd31, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 6'd20, 1'b0);
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 1'b0);

    // Held press, release, 1-cycle glitch, 10-cycle pulse.
    for (int n = 0; n < 25; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    for (int n = 0; n < 25; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    for (int n = 0; n < 25; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    for (int n = 0; n < 25; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Reset in the middle of a debounce with the switch still held.
    for (int n = 0; n < 8; n++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
    do_reset(1'b1);
    for (int n = 0; n < 25; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    for (int n = 0; n < 25; n++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Random controls, random switch run lengths, occasional reset.
    sw_r = 1'b0;
    run  = 0;
    for (int n = 0; n < 400; n++) begin
      if (run == 0) begin
        sw_r = ~sw_r;
        run  = int'($urandom_range(1, 24));
      end
      run--;
      if ($urandom_range(0, 99) == 0) do_reset(sw_r);
      cycle(1'b1, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
            6'($urandom), sw_r);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
